// File: rtl/port_dev_pkg.sv
// Shared constants and the status word layout for the per-port queue device.
package port_dev_pkg;

  localparam int unsigned PORT_WORD_W = 16;
  localparam int unsigned MAX_DEPTH   = 8;
  localparam int unsigned CNT_W       = 4;

  localparam int unsigned CMD_PUSH      = 0;
  localparam int unsigned CMD_CLR_TX    = 1;
  localparam int unsigned CMD_CLR_RX    = 2;
  localparam int unsigned CMD_CLR_FLAGS = 3;

  localparam int unsigned ST_RX_NONEMPTY = 15;
  localparam int unsigned ST_TX_FULL     = 14;
  localparam int unsigned ST_RX_OVF      = 13;
  localparam int unsigned ST_TX_OVF      = 12;
  localparam int unsigned ST_RX_CNT_LSB  = 4;
  localparam int unsigned ST_TX_CNT_LSB  = 0;

  typedef struct packed {
    logic             rx_nonempty;
    logic             tx_full;
    logic             rx_ovf;
    logic             tx_ovf;
    logic [3:0]       rsvd;
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] tx_count;
  } port_status_t;

  function automatic logic [PORT_WORD_W-1:0] pack_status(
    input logic             rx_nonempty,
    input logic             tx_full,
    input logic             rx_ovf,
    input logic             tx_ovf,
    input logic [CNT_W-1:0] rx_count,
    input logic [CNT_W-1:0] tx_count
  );
    port_status_t s;
    s.rx_nonempty = rx_nonempty;
    s.tx_full     = tx_full;
    s.rx_ovf      = rx_ovf;
    s.tx_ovf      = tx_ovf;
    s.rsvd        = '0;
    s.rx_count    = rx_count;
    s.tx_count    = tx_count;
    return s;
  endfunction

endpackage

// File: rtl/port_sync_fifo.sv
// Synchronous FIFO with clear; a push in the clear cycle lands as the sole entry.
module port_sync_fifo
  import port_dev_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [PORT_WORD_W-1:0] din,
  output logic [PORT_WORD_W-1:0] dout,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [PORT_WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   w_pop;
  logic                   w_push;
  logic [AW-1:0]          w_wr_idx;

  assign w_pop    = pop & (r_count != '0);
  assign w_push   = push & (clear | (r_count < CNT_W'(DEPTH)) | w_pop);
  assign w_wr_idx = clear ? '0 : r_wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= w_push ? AW'(1) : '0;
      r_count  <= w_push ? CNT_W'(1) : '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[w_wr_idx] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/port_queue_dev.sv
// CPU port responder: command decode, TX/RX queues, sticky flags and status word.
module port_queue_dev
  import port_dev_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORT_WORD_W-1:0] port_d_out_data,
  input  logic [PORT_WORD_W-1:0] port_d_out_cmd,
  input  logic                   port_inform_write,
  input  logic                   port_inform_read,
  output logic [PORT_WORD_W-1:0] port_d_in_data,
  output logic [PORT_WORD_W-1:0] port_d_in_status,
  output logic [PORT_WORD_W-1:0] tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [PORT_WORD_W-1:0] rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready
);

  logic                   w_push, w_clr_tx, w_clr_rx, w_clr_flags;
  logic                   w_unused_cmd;
  logic                   w_tx_pop, w_tx_full, w_tx_empty, w_tx_ovf_set;
  logic                   w_rx_hs, w_rx_push, w_rx_full, w_rx_empty, w_rx_ovf_set;
  logic [CNT_W-1:0]       w_tx_count, w_rx_count;
  logic [PORT_WORD_W-1:0] w_rx_dout;
  logic                   r_tx_ovf, r_rx_ovf;

  assign w_push       = port_inform_write & port_d_out_cmd[CMD_PUSH];
  assign w_clr_tx     = port_inform_write & port_d_out_cmd[CMD_CLR_TX];
  assign w_clr_rx     = port_inform_write & port_d_out_cmd[CMD_CLR_RX];
  assign w_clr_flags  = port_inform_write & port_d_out_cmd[CMD_CLR_FLAGS];
  assign w_unused_cmd = ^port_d_out_cmd[PORT_WORD_W-1:4];

  assign tx_valid     = ~w_tx_empty;
  assign w_tx_pop     = tx_valid & tx_ready;
  assign w_tx_ovf_set = w_push & ~w_clr_tx & w_tx_full & ~w_tx_pop;

  // A read pulse frees a slot this cycle, so a full RX may still accept.
  assign rx_ready     = (~w_rx_full | port_inform_read) & ~rst;
  assign w_rx_hs      = rx_valid & rx_ready;
  assign w_rx_push    = w_rx_hs & ~w_clr_rx;
  assign w_rx_ovf_set = rx_valid & ~rx_ready;

  port_sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_tx_pop),
    .clear (w_clr_tx),
    .din   (port_d_out_data),
    .dout  (tx_data),
    .count (w_tx_count),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

  port_sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rx_push),
    .pop   (port_inform_read),
    .clear (w_clr_rx),
    .din   (rx_data),
    .dout  (w_rx_dout),
    .count (w_rx_count),
    .full  (w_rx_full),
    .empty (w_rx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
    end else begin
      r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~w_clr_flags);
      r_rx_ovf <= w_rx_ovf_set | (r_rx_ovf & ~w_clr_flags);
    end
  end

  assign port_d_in_data   = w_rx_empty ? '0 : w_rx_dout;
  assign port_d_in_status = pack_status(~w_rx_empty, w_tx_full, r_rx_ovf, r_tx_ovf,
                                        w_rx_count, w_tx_count);

endmodule

// File: tb/tb_port_queue_dev.sv
// Directed bench for port_queue_dev (DEPTH=8) with hand-computed expectations.
module tb_port_queue_dev;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] port_d_out_data, port_d_out_cmd;
  logic        port_inform_write, port_inform_read;
  logic [15:0] port_d_in_data, port_d_in_status, tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  port_queue_dev #(.DEPTH(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .port_d_out_data   (port_d_out_data),
    .port_d_out_cmd    (port_d_out_cmd),
    .port_inform_write (port_inform_write),
    .port_inform_read  (port_inform_read),
    .port_d_in_data    (port_d_in_data),
    .port_d_in_status  (port_d_in_status),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] cmd, input logic [15:0] data);
    port_d_out_cmd    = cmd;
    port_d_out_data   = data;
    port_inform_write = 1'b1;
    tick();
    port_inform_write = 1'b0;
  endtask

  task automatic cpu_read();
    port_inform_read = 1'b1;
    tick();
    port_inform_read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    port_d_out_cmd = '0; port_d_out_data = '0;
    port_inform_write = 1'b0; port_inform_read = 1'b0;
    tick(); tick();
    n_total++; if (rx_ready !== 1'b0) $display("FAIL reset_rx_ready_low got %b exp 0", rx_ready); else n_pass++;
    rst = 1'b0; #1;
    n_total++; if (port_d_in_status !== 16'h0000) $display("FAIL reset_status got %h exp 0000", port_d_in_status); else n_pass++;
    n_total++; if (port_d_in_data !== 16'h0000) $display("FAIL reset_data got %h exp 0000", port_d_in_data); else n_pass++;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b exp 0", tx_valid); else n_pass++;
    n_total++; if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready_high got %b exp 1", rx_ready); else n_pass++;
  endtask

  task automatic test_push();
    cpu_write(16'h0001, 16'hA5A5);
    n_total++; if (port_d_in_status !== 16'h0001) $display("FAIL push_status got %h exp 0001", port_d_in_status); else n_pass++;
    n_total++; if (tx_valid !== 1'b1) $display("FAIL push_tx_valid got %b exp 1", tx_valid); else n_pass++;
    n_total++; if (tx_data !== 16'hA5A5) $display("FAIL push_tx_data got %h exp a5a5", tx_data); else n_pass++;
    cpu_write(16'h0002, 16'h0000);
    n_total++; if (port_d_in_status !== 16'h0000) $display("FAIL clr_tx_status got %h exp 0000", port_d_in_status); else n_pass++;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL clr_tx_valid got %b exp 0", tx_valid); else n_pass++;
  endtask

  task automatic test_tx_overflow();
    for (int i = 0; i < 9; i++) cpu_write(16'h0001, 16'h1000 + 16'(i));
    n_total++; if (port_d_in_status !== 16'h5008) $display("FAIL tx_ovf_status got %h exp 5008", port_d_in_status); else n_pass++;
    n_total++; if (tx_data !== 16'h1000) $display("FAIL tx_ovf_head got %h exp 1000", tx_data); else n_pass++;
    cpu_write(16'h0008, 16'h0000);
    n_total++; if (port_d_in_status !== 16'h4008) $display("FAIL clr_flags_status got %h exp 4008", port_d_in_status); else n_pass++;
    cpu_write(16'h0009, 16'hDEAD);
    n_total++; if (port_d_in_status !== 16'h5008) $display("FAIL set_wins_status got %h exp 5008", port_d_in_status); else n_pass++;
    cpu_write(16'h0008, 16'h0000);
    n_total++; if (port_d_in_status !== 16'h4008) $display("FAIL clr_flags2_status got %h exp 4008", port_d_in_status); else n_pass++;
  endtask

  task automatic test_full_pop_push();
    tx_ready = 1'b1;
    cpu_write(16'h0001, 16'hBEEF);
    tx_ready = 1'b0; #1;
    n_total++; if (port_d_in_status !== 16'h4008) $display("FAIL full_pop_push_status got %h exp 4008", port_d_in_status); else n_pass++;
    n_total++; if (tx_data !== 16'h1001) $display("FAIL full_pop_push_head got %h exp 1001", tx_data); else n_pass++;
    cpu_write(16'h0002, 16'h0000);
    n_total++; if (port_d_in_status !== 16'h0000) $display("FAIL drain_status got %h exp 0000", port_d_in_status); else n_pass++;
  endtask

  task automatic test_rx_read();
    rx_valid = 1'b1; rx_data = 16'h0055; tick();
    rx_data = 16'h0066; tick();
    rx_valid = 1'b0; #1;
    n_total++; if (port_d_in_status !== 16'h8020) $display("FAIL rx2_status got %h exp 8020", port_d_in_status); else n_pass++;
    n_total++; if (port_d_in_data !== 16'h0055) $display("FAIL rx_head0 got %h exp 0055", port_d_in_data); else n_pass++;
    cpu_read();
    n_total++; if (port_d_in_data !== 16'h0066) $display("FAIL rx_head1 got %h exp 0066", port_d_in_data); else n_pass++;
    n_total++; if (port_d_in_status !== 16'h8010) $display("FAIL rx1_status got %h exp 8010", port_d_in_status); else n_pass++;
    cpu_read();
    n_total++; if (port_d_in_data !== 16'h0000) $display("FAIL rx_head2 got %h exp 0000", port_d_in_data); else n_pass++;
    cpu_read();
    n_total++; if (port_d_in_status !== 16'h0000) $display("FAIL rx_empty_pop_status got %h exp 0000", port_d_in_status); else n_pass++;
  endtask

  task automatic test_rx_overflow();
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 16'h2000 + 16'(i);
      tick();
    end
    rx_data = 16'h2008; #1;
    n_total++; if (rx_ready !== 1'b0) $display("FAIL rx_full_ready got %b exp 0", rx_ready); else n_pass++;
    tick();
    rx_data = 16'h2009; port_inform_read = 1'b1; #1;
    n_total++; if (rx_ready !== 1'b1) $display("FAIL rx_full_read_ready got %b exp 1", rx_ready); else n_pass++;
    tick();
    port_inform_read = 1'b0; rx_valid = 1'b0; #1;
    n_total++; if (port_d_in_status !== 16'hA080) $display("FAIL rx_ovf_status got %h exp a080", port_d_in_status); else n_pass++;
    n_total++; if (port_d_in_data !== 16'h2001) $display("FAIL rx_ovf_head got %h exp 2001", port_d_in_data); else n_pass++;
    cpu_write(16'h000C, 16'h0000);
    n_total++; if (port_d_in_status !== 16'h0000) $display("FAIL rx_clr_status got %h exp 0000", port_d_in_status); else n_pass++;
  endtask

  task automatic test_clear_combo();
    for (int i = 0; i < 3; i++) cpu_write(16'h0001, 16'h3000 + 16'(i));
    rx_valid = 1'b1; rx_data = 16'h0011; tick();
    rx_data = 16'h0022; tick();
    rx_data = 16'h7777;
    n_total++; if (port_d_in_status !== 16'h8023) $display("FAIL combo_pre_status got %h exp 8023", port_d_in_status); else n_pass++;
    cpu_write(16'h0007, 16'h1234);
    rx_valid = 1'b0; #1;
    n_total++; if (port_d_in_status !== 16'h0001) $display("FAIL combo_status got %h exp 0001", port_d_in_status); else n_pass++;
    n_total++; if (tx_data !== 16'h1234) $display("FAIL combo_tx_data got %h exp 1234", tx_data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_write(16'h0001, 16'h4000 + 16'(i));
      n_total++; if (port_d_in_status !== 16'h0001) $display("FAIL b2b_status%0d got %h exp 0001", i, port_d_in_status); else n_pass++;
      n_total++; if (tx_data !== 16'h4000 + 16'(i)) $display("FAIL b2b_data%0d got %h exp %h", i, tx_data, 16'h4000 + 16'(i)); else n_pass++;
    end
    tick();
    tx_ready = 1'b0; #1;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL b2b_drain_valid got %b exp 0", tx_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    cpu_write(16'h0001, 16'h5000);
    cpu_write(16'h0001, 16'h5001);
    rx_valid = 1'b1; rx_data = 16'h0033; tick(); tick();
    n_total++; if (port_d_in_status !== 16'h8022) $display("FAIL mid_pre_status got %h exp 8022", port_d_in_status); else n_pass++;
    rst = 1'b1; port_d_out_cmd = 16'h0001; port_d_out_data = 16'h5555; port_inform_write = 1'b1; #1;
    n_total++; if (rx_ready !== 1'b0) $display("FAIL mid_rx_ready got %b exp 0", rx_ready); else n_pass++;
    tick();
    rst = 1'b0; port_inform_write = 1'b0; rx_valid = 1'b0; #1;
    n_total++; if (port_d_in_status !== 16'h0000) $display("FAIL mid_status got %h exp 0000", port_d_in_status); else n_pass++;
    n_total++; if (port_d_in_data !== 16'h0000) $display("FAIL mid_data got %h exp 0000", port_d_in_data); else n_pass++;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL mid_tx_valid got %b exp 0", tx_valid); else n_pass++;
    n_total++; if (rx_ready !== 1'b1) $display("FAIL mid_rx_ready_after got %b exp 1", rx_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_push();
    test_tx_overflow();
    test_full_pop_push();
    test_rx_read();
    test_rx_overflow();
    test_clear_combo();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/port_queue_dev.md
# port_queue_dev

Peripheral attached to one CPU I/O port; the device end of the port protocol the `cpu` drives. It is the responder to the CPU's port writes and reads.
- On a port write, it decodes the command word and either pushes the data word into a TX queue or clears state.
- It presents the RX queue head and a status word to the CPU, and pops the RX queue on a port read.
- It exchanges 16-bit words with an external agent over valid/ready streams.
- Instantiated per port, between `cpu` and off-core devices.

## Interface
Parameters:
- `DEPTH`, 8: entries per queue; legal values 2, 4, 8.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `port_d_out_data`  in  16  CPU data word, from `port_d_out[2*p]`.
- `port_d_out_cmd`  in  16  CPU command word, from `port_d_out[2*p+1]`.
- `port_inform_write`  in  1  one-cycle pulse: the CPU executed a port write this cycle.
- `port_inform_read`  in  1  one-cycle pulse: the CPU sampled the port inputs this cycle.
- `port_d_in_data`  out  16  RX head word, to `port_d_in[2*p]`.
- `port_d_in_status`  out  16  status word, to `port_d_in[2*p+1]`.
- `tx_data`  out  16  TX head word.
- `tx_valid`  out  1  TX queue non-empty.
- `tx_ready`  in  1  external consumer accepts.
- `rx_data`  in  16  external word.
- `rx_valid`  in  1  external word offered.
- `rx_ready`  out  1  device accepts.

## Operation
Command bits, acted on only when `port_inform_write`=1:
- [0] PUSH: enqueue `port_d_out_data` into TX.
- [1] CLR_TX: empty the TX queue.
- [2] CLR_RX: empty the RX queue.
- [3] CLR_FLAGS: clear the sticky flags.
- [15:4]: ignored.

Precedence within one write:
- Clears apply first, then PUSH. CLR_TX together with PUSH leaves exactly the new word in TX.
- CLR_FLAGS together with an overflowing PUSH leaves tx_ovf=1, because set wins over clear.

TX queue:
- PUSH succeeds if TX count < DEPTH, or if a TX handshake (`tx_valid & tx_ready`) pops in the same cycle.
- Otherwise the word is dropped and sticky tx_ovf is set.

RX queue:
- `rx_ready` = (RX count < DEPTH | `port_inform_read`) & !`rst`.
- An RX handshake enqueues `rx_data`.
- If CLR_RX coincides with an RX handshake, the handshake completes but the word is discarded; the queue ends empty.
- rx_ovf sets when `rx_valid`=1 and `rx_ready`=0 for a cycle.

CPU read:
- A `port_inform_read` pulse pops the RX head if the queue is non-empty.
- Pop on empty: no effect, no flag.

Status word:
- [15] rx_nonempty
- [14] tx_full
- [13] rx_ovf (sticky)
- [12] tx_ovf (sticky)
- [11:8] always 0
- [7:4] rx_count
- [3:0] tx_count

`port_d_in_data` = RX head when non-empty, else 16'h0000. `tx_data` = TX head; its value is undefined when `tx_valid`=0 and must not be checked.

Queue arithmetic:
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Counts are 4-bit, range 0..DEPTH.
- Simultaneous push and pop leaves the count unchanged.

## Timing
- All state updates on the rising edge of `clk`.
- `port_d_in_data`, `port_d_in_status`, `tx_data` and `tx_valid` are combinational from registered state, so they reflect the state after the most recent edge.
- A CPU write at edge N is visible in status and on `tx_valid` after edge N.
- The CPU samples `port_d_in_*` in the same cycle it pulses `port_inform_read`; the pop takes effect at the next edge.
- Back-to-back pulses on consecutive cycles each act once; sustained throughput is one push per cycle per queue.
- Reset: while `rst`=1 at an edge, pointers, counts and flags return to 0. The cycle after reset:
  - `port_d_in_data`=0
  - `port_d_in_status`=0
  - `tx_valid`=0
  - `rx_ready`=1
- Reset mid-transfer discards all queued words; a handshake in the reset cycle is ignored.
- `rx_ready` is 0 whenever `rst`=1.

## Structure
- Package `port_dev_pkg`:
  - command bit indices (CMD_PUSH, CMD_CLR_TX, CMD_CLR_RX, CMD_CLR_FLAGS);
  - status bit/field positions;
  - `PORT_WORD_W` = 16;
  - `MAX_DEPTH` = 8.
- Sub-module `port_sync_fifo`:
  - parameterised by DEPTH;
  - ports: push, pop, clear, din, dout, count, full, empty;
  - synchronous clear;
  - instantiated twice, once for TX and once for RX.
- Top level holds the command decode, flag registers, status assembly and handshake logic.

## Test plan
- Reset, then write cmd=16'h0001 with data 16'hA5A5, `tx_ready`=0 → status=16'h0001, `tx_valid`=1, `tx_data`=16'hA5A5.
- With DEPTH=8, nine PUSH writes and `tx_ready`=0 → tx_count=8, status[14]=1, status[12]=1. Then cmd=16'h0008 → status[12]=0.
- External agent sends 16'h0055 then 16'h0066; CPU issues three read pulses:
  - before each pulse, `port_d_in_data` = 0x0055, then 0x0066, then 0x0000;
  - the third pop is harmless; rx_count ends at 0.
- TX full with `tx_ready`=1 and a PUSH in the same cycle → push accepted, tx_count stays 8, status[12]=0.
- Write cmd=16'h0007 with data 16'h1234 while TX holds 3 words and RX holds 2 → next cycle tx_count=1, rx_count=0, `tx_data`=16'h1234.
- Assert `rst` with both queues partly full and `rx_valid`=1 → `rx_ready`=0 during reset; the cycle after, all outputs at their reset values.
